// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per operation.
// Latency: WIDTH+2 edges from the accepting edge to done; data-dependent when SEQ_MULT_EARLY_TERM_EN is defined.
// Backpressure: start is ignored while busy or done is high; there is no queueing.
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mult_1,
    input  logic [WIDTH-1:0]   mult_2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovr
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH:0]   acc, acc_nxt, acc_add, acc_step;
    logic [WIDTH:0]     upper_sum;
    logic [WIDTH-1:0]   mcand, m1_mag, m2_mag;
    logic [CW-1:0]      cnt;
    logic               neg, sgn, accept, last;
    logic [2*WIDTH-1:0] prod_fix;
    logic               ovr_fix;

    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);
    assign last   = (cnt == CW'(WIDTH - 1));

    assign m1_mag = (signed_mode && mult_1[WIDTH-1]) ? (~mult_1 + ONE_W) : mult_1;
    assign m2_mag = (signed_mode && mult_2[WIDTH-1]) ? (~mult_2 + ONE_W) : mult_2;

    assign upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    assign acc_add   = acc[0] ? {upper_sum, acc[WIDTH-1:0]} : acc;
    assign acc_step  = acc_add >> 1;

    assign prod_fix = neg ? (~acc[2*WIDTH-1:0] + ONE_2W) : acc[2*WIDTH-1:0];
    // Signed result fits when the top WIDTH+1 bits are a pure sign extension.
    assign ovr_fix  = sgn ? ~((&prod_fix[2*WIDTH-1:WIDTH-1]) | ~(|prod_fix[2*WIDTH-1:WIDTH-1]))
                          : (|prod_fix[2*WIDTH-1:WIDTH]);

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic             rem_zero;
    // After cnt shifts the unconsumed multiplier bits sit in acc[WIDTH-1-cnt:0].
    assign rem_mask = {WIDTH{1'b1}} >> cnt;
    assign rem_zero = ((acc[WIDTH-1:0] & rem_mask) == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (rem_zero) begin
                    acc_nxt   = acc >> (CW'(WIDTH) - cnt);
                    state_nxt = FIX;
                end else begin
                    acc_nxt = acc_step;
                    if (last) state_nxt = FIX;
                end
`else
                acc_nxt = acc_step;
                if (last) state_nxt = FIX;
`endif
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sgn     <= 1'b0;
            product <= '0;
            ovr     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                acc   <= {{(WIDTH+1){1'b0}}, m2_mag};
                mcand <= m1_mag;
                cnt   <= '0;
                sgn   <= signed_mode;
                // A zero operand forces a positive result so no negation is applied.
                neg   <= signed_mode & (mult_1[WIDTH-1] ^ mult_2[WIDTH-1]) & (|mult_1) & (|mult_2);
            end else if (state == RUN) begin
                acc <= acc_nxt;
                cnt <= cnt + CW'(1);
            end
            if (state == FIX) begin
                product <= prod_fix;
                ovr     <= ovr_fix;
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed 8-bit cases and randomized 64-bit cases against an integer model.
module tb_seq_multiplier;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         s8, sm8, busy8, done8, ovr8;
    logic [7:0]   a8, b8;
    logic [15:0]  p8;
    logic         s64, sm64, busy64, done64, ovr64;
    logic [63:0]  a64, b64;
    logic [127:0] p64;

    int errors = 0;
    int checks = 0;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8),
        .mult_1(a8), .mult_2(b8), .busy(busy8), .done(done8),
        .product(p8), .ovr(ovr8)
    );

    seq_multiplier #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(s64), .signed_mode(sm64),
        .mult_1(a64), .mult_2(b64), .busy(busy64), .done(done64),
        .product(p64), .ovr(ovr64)
    );

    // Exact integer product of the w-bit operands, truncated to 2w bits; ovr from the value range.
    task automatic ref_mul(input logic sm, input logic [63:0] a, input logic [63:0] b, input int w,
                           output logic [127:0] p, output logic o);
        logic signed [127:0] sa, sb, full, lim;
        logic [127:0] mask;
        sa = $signed({64'd0, a});
        sb = $signed({64'd0, b});
        if (sm && a[w-1]) sa = sa - (128'sd1 <<< w);
        if (sm && b[w-1]) sb = sb - (128'sd1 <<< w);
        full = sa * sb;
        mask = (128'd1 << (2 * w)) - 128'd1;
        p    = full & mask;
        if (sm) begin
            lim = 128'sd1 <<< (w - 1);
            o   = (full < -lim) || (full > lim - 128'sd1);
        end else begin
            o   = (full >= (128'sd1 <<< w));
        end
    endtask

    task automatic do_op8(input string name, input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ep, input logic eo);
        int lat;
        logic [15:0] pprev;
        pprev = p8;
        @(negedge clk);
        s8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        @(posedge clk); #1;
        s8 = 1'b0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom);
        checks++;
        if (busy8 !== 1'b1 || p8 !== pprev) begin
            errors++;
            $display("FAIL %s accept: busy=%b product=%h, required busy=1 product=%h", name, busy8, p8, pprev);
        end
        lat = 0;
        while (done8 !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (p8 !== ep || ovr8 !== eo) begin
            errors++;
            $display("FAIL %s result: product=%h ovr=%b, required product=%h ovr=%b", name, p8, ovr8, ep, eo);
        end
        checks++;
        if (EARLY ? (lat < 3 || lat > 10) : (lat != 10)) begin
            errors++;
            $display("FAIL %s latency: %0d edges, required %s", name, lat, EARLY ? "3..10" : "10");
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0 || p8 !== ep) begin
            errors++;
            $display("FAIL %s pulse: done=%b product=%h, required done=0 product=%h", name, done8, p8, ep);
        end
    endtask

    task automatic do_op64(input int idx, input logic sm, input logic [63:0] a, input logic [63:0] b);
        int lat;
        logic [127:0] ep;
        logic eo;
        ref_mul(sm, a, b, 64, ep, eo);
        @(negedge clk);
        s64 = 1'b1; sm64 = sm; a64 = a; b64 = b;
        @(posedge clk); #1;
        s64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        lat = 0;
        while (done64 !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (p64 !== ep || ovr64 !== eo) begin
            errors++;
            $display("FAIL rand64[%0d] sm=%b a=%h b=%h: product=%h ovr=%b, required product=%h ovr=%b",
                     idx, sm, a, b, p64, ovr64, ep, eo);
        end
        checks++;
        if (EARLY ? (lat < 3 || lat > 66 || (b == 64'd1 && lat > 4)) : (lat != 66)) begin
            errors++;
            $display("FAIL rand64[%0d] latency: %0d edges for b=%h", idx, lat, b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        s64 = 1'b0; sm64 = 1'b0; a64 = '0; b64 = '0;
        #23;
        checks++;
        if ({busy8, done8, ovr8, busy64, done64, ovr64} !== 6'b0 || p8 !== 16'h0 || p64 !== 128'h0) begin
            errors++;
            $display("FAIL reset: busy8=%b done8=%b p8=%h busy64=%b done64=%b p64=%h, required all zero",
                     busy8, done8, p8, busy64, done64, p64);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        do_op8("u200x3", 1'b0, 8'd200, 8'd3, 16'h0258, 1'b1);
        do_op8("u15x17", 1'b0, 8'd15, 8'd17, 16'h00FF, 1'b0);
        do_op8("uFFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    endtask

    task automatic test_signed;
        do_op8("s-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
        do_op8("s-3x5",      1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0);
        do_op8("s127x-1",    1'b1, 8'h7F, 8'hFF, 16'hFF81, 1'b0);
    endtask

    task automatic test_boundary;
        do_op8("s-16x8", 1'b1, 8'hF0, 8'h08, 16'hFF80, 1'b0);
        do_op8("s16x8",  1'b1, 8'h10, 8'h08, 16'h0080, 1'b1);
        do_op8("s0x-1",  1'b1, 8'h00, 8'hFF, 16'h0000, 1'b0);
        do_op8("u0x0",   1'b0, 8'h00, 8'h00, 16'h0000, 1'b0);
    endtask

    task automatic test_ignore_start;
        int cyc, dn;
        @(negedge clk);
        s8 = 1'b1; sm8 = 1'b0; a8 = 8'd15; b8 = 8'd17;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
        @(negedge clk);
        s8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL ignore_start timeout: no done within %0d cycles", cyc);
        end
        // Request raised in the done cycle must not be accepted.
        s8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        @(negedge clk);
        s8 = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8 === 1'b1) dn++;
        end
        checks++;
        if (dn != 0 || p8 !== 16'h00FF || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: extra done=%0d product=%h busy=%b, required 0 00ff 0", dn, p8, busy8);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        @(negedge clk);
        s8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0 || ovr8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b product=%h ovr=%b, required all zero",
                     busy8, done8, p8, ovr8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8 === 1'b1) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL reset_mid done: %0d pulses after abandoned op, required 0", dn);
        end
        do_op8("u7x9", 1'b0, 8'd7, 8'd9, 16'h003F, 1'b0);
    endtask

    task automatic test_random64;
        logic [63:0] a, b;
        logic sm;
        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom} >> $urandom_range(0, 63);
            case ($urandom_range(0, 7))
                0: a = 64'h0;
                1: a = 64'h8000_0000_0000_0000;
                2: b = 64'hFFFF_FFFF_FFFF_FFFF;
                3: b = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            do_op64(i, sm, a, b);
        end
    endtask

    task automatic test_early64;
        do_op64(100, 1'b0, {$urandom, $urandom}, 64'd1);
        do_op64(101, 1'b1, 64'h8000_0000_0000_0000, 64'd1);
        do_op64(102, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0);
        do_op64(103, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundary();
        test_ignore_start();
        test_reset_mid();
        test_random64();
        test_early64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit consumed per clock.
- Successor to the combinational multiplier in the ALU path. Adds a parametrised width, a per-operation signed/unsigned mode, a start/done handshake, and a correct overflow flag.
- Sits beside the ALU. The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 64, operand width in bits (min 4); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- mult_1  input  WIDTH  multiplicand; sampled with start
- mult_2  input  WIDTH  multiplier; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; product and ovr are valid
- product  output  2*WIDTH  result; held until the next accepted start
- ovr  output  1  result does not fit in WIDTH bits; held with product

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, product=0, ovr=0; internal registers cleared.
  - Reset mid-operation abandons the operation. No done pulse is issued.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at an edge -> latch operands, go to RUN.
  - Latching captures:
    - neg = signed_mode & (mult_1[W-1] ^ mult_2[W-1]).
    - mcand = |mult_1| and mplier = |mult_2| when signed_mode=1, else the raw values.
    - Magnitude is computed as ~x+1. The most-negative value maps to 2^(W-1), which fits in WIDTH unsigned bits.
  - Accumulator acc[2W:0] = {0, mplier}. Step counter cnt = 0.
- RUN, one iteration per cycle:
  - If acc[0] = 1, add mcand into acc[2W:W] with carry into bit 2W.
  - Then shift acc right by 1. cnt increments.
  - After WIDTH iterations (cnt = WIDTH-1 processed) -> FIX.
- FIX:
  - product = neg ? (~acc[2W-1:0] + 1) : acc[2W-1:0].
  - ovr computed from the final product:
    - unsigned: |product[2W-1:W].
    - signed: product[2W-1:W-1] is neither all-0 nor all-1.
  - -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 from this cycle onward.
- Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH+2. Fixed latency regardless of data (see optional feature).
- start while busy or done is high: ignored. There is no queueing.
- start asserted in the same cycle done is high: ignored. The request must be held or re-asserted in IDLE.
- Operand inputs may change freely after acceptance. Only the latched copies are used.
- Zero operand:
  - Runs the full WIDTH cycles; product = 0, ovr = 0.
  - neg is forced 0 when the result is zero, so there is no "negative zero" artefact (~0+1 wraps to 0 anyway).
- product and ovr update only in FIX. They are stable at all other times.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, if the unconsumed multiplier bits of acc (acc[WIDTH-1-cnt:0] region, i.e. the remaining mplier bits) are all zero, the remaining shifts are performed in one step: acc shifted right by (WIDTH - cnt). The FSM then goes to FIX.
  - Latency becomes data-dependent. Minimum is 3 cycles to done for mplier = 0.
  - Results are identical to the non-early build.
- Undefined: fixed latency as above; no early-exit logic is synthesised.

Test Plan:
- WIDTH=8, unsigned, 200 x 3 -> done after 11 cycles, product=0x0258, ovr=1. Then 15 x 17 -> product=0x00FF, ovr=0.
- WIDTH=8, signed, -128 x -128 -> product=0x4000, ovr=1. Then -3 x 5 -> product=0xFFF1, ovr=0. Then 127 x -1 -> product=0xFF81, ovr=0.
- WIDTH=8, signed, -16 x 8 -> product=0xFF80, ovr=0 (fits exactly). Then 16 x 8 -> product=0x0080, ovr=1.
- start pulsed again at cycles 3 and at the done cycle of an operation -> both ignored; only one done pulse; product unchanged until a new start in IDLE.
- rst_n dropped to 0 at cycle 5 of RUN -> outputs 0 immediately (async). Release, then start 7 x 9 unsigned -> product=0x003F, clean done.
- WIDTH=64, random signed/unsigned pairs, checked against a reference model:
  - With SEQ_MULT_EARLY_TERM_EN defined: mplier=1 gives done within 4 cycles, and results match the non-early build bit-for-bit.
